// File: rtl/fractal_sync_root.sv
// Root responder of the fractal sync tree: one IDLE/DELAY/WAKE responder per port
// with level check, forced-error injection, bounded ack wait and saturating statistics.
module fractal_sync_root #(
  parameter int unsigned N_PORTS     = 1,
  parameter int unsigned LVL_WIDTH   = 1,
  parameter int unsigned ROOT_LVL    = 1,
  parameter int unsigned RESP_LAT    = 1,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [N_PORTS-1:0]           sync_i,
  input  logic [N_PORTS*LVL_WIDTH-1:0] level_i,
  input  logic [N_PORTS-1:0]           ack_i,
  input  logic                         err_force_i,
  output logic [N_PORTS-1:0]           wake_o,
  output logic [N_PORTS-1:0]           error_o,
  output logic [N_PORTS-1:0]           timeout_o,
  output logic [CNT_WIDTH-1:0]         sync_cnt_o,
  output logic [CNT_WIDTH-1:0]         err_cnt_o
);

  localparam int unsigned DW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned PW = $clog2(N_PORTS + 1);
  localparam logic [LVL_WIDTH-1:0] ROOT_LVL_L = LVL_WIDTH'(ROOT_LVL);
  localparam logic [DW-1:0]        DLY_INIT   = DW'(RESP_LAT - 1);
  localparam logic [TW-1:0]        TO_LAST    = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam bit                   TO_EN      = (ACK_TIMEOUT > 0);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_WAKE} state_e;

  logic [N_PORTS-1:0] w_accept;
  logic [N_PORTS-1:0] w_acc_err;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    state_e               r_state;
    state_e               w_state_nxt;
    logic                 r_armed;
    logic                 r_resp_err;
    logic                 r_timeout;
    logic [DW-1:0]        r_dly_cnt;
    logic [TW-1:0]        r_to_cnt;
    logic                 w_timeout_evt;
    logic                 w_wake;
    logic                 w_error;
    logic [LVL_WIDTH-1:0] w_level;

    assign w_level      = level_i[p*LVL_WIDTH +: LVL_WIDTH];
    assign w_accept[p]  = (r_state == S_IDLE) && sync_i[p] && r_armed;
    assign w_acc_err[p] = w_accept[p] && ((w_level != ROOT_LVL_L) || err_force_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_state    <= S_IDLE;
        r_armed    <= 1'b1;
        r_resp_err <= 1'b0;
        r_timeout  <= 1'b0;
        r_dly_cnt  <= '0;
        r_to_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        // A request held high across completion must drop for one edge before re-accept
        if (!sync_i[p])
          r_armed <= 1'b1;
        else if (w_accept[p])
          r_armed <= 1'b0;
        if (w_accept[p]) begin
          r_resp_err <= w_acc_err[p];
          r_dly_cnt  <= DLY_INIT;
        end else if (r_state == S_DELAY) begin
          r_dly_cnt <= r_dly_cnt - DW'(1);
        end
        if (r_state == S_WAKE)
          r_to_cnt <= r_to_cnt + TW'(1);
        else
          r_to_cnt <= '0;
        if (w_timeout_evt)
          r_timeout <= 1'b1;
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_timeout_evt = 1'b0;
      case (r_state)
        S_IDLE:  if (w_accept[p]) w_state_nxt = (RESP_LAT == 1) ? S_WAKE : S_DELAY;
        S_DELAY: if (r_dly_cnt == DW'(1)) w_state_nxt = S_WAKE;
        S_WAKE: begin
          if (ack_i[p]) begin
            w_state_nxt = S_IDLE;
          end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
            w_state_nxt   = S_IDLE;
            w_timeout_evt = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    always_comb begin
      w_wake  = (r_state == S_WAKE);
      w_error = w_wake && r_resp_err;
    end

    assign wake_o[p]    = w_wake;
    assign error_o[p]   = w_error;
    assign timeout_o[p] = r_timeout;
  end

  logic [PW-1:0] w_acc_pop;
  logic [PW-1:0] w_err_pop;

  always_comb begin
    w_acc_pop = '0;
    w_err_pop = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      w_acc_pop = w_acc_pop + PW'(w_accept[i]);
      w_err_pop = w_err_pop + PW'(w_acc_err[i]);
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PW-1:0] b);
    logic [CNT_WIDTH+PW-1:0] s;
    s = {{PW{1'b0}}, a} + {{CNT_WIDTH{1'b0}}, b};
    if (s > {{PW{1'b0}}, {CNT_WIDTH{1'b1}}})
      return '1;
    return s[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0] r_sync_cnt;
  logic [CNT_WIDTH-1:0] r_err_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_sync_cnt <= sat_add(r_sync_cnt, w_acc_pop);
      r_err_cnt  <= sat_add(r_err_cnt, w_err_pop);
    end
  end

  assign sync_cnt_o = r_sync_cnt;
  assign err_cnt_o  = r_err_cnt;

endmodule
